// File: rtl/nibbleadd_seq.sv
// nibbleadd_seq: wide adder sequencer built around a shared 4-bit nibble adder.
// It captures an operand pair and a carry-in, then feeds the adder one nibble
// pair per cycle, low nibble first. The carry ripples through a local register
// between steps, and the finished sum and carry-out are returned over a
// valid/ready handshake.
module nibbleadd_seq #(
   parameter int NBYTES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NBYTES-1:0]   in_a,
   input  logic [8*NBYTES-1:0]   in_b,
   input  logic                  in_cin,
   output logic [7:0]            na_a,
   output logic [7:0]            na_b,
   output logic                  na_ctrl,
   input  logic [4:0]            na_q,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   out_sum,
   output logic                  out_cout,
   output logic                  busy
);

   localparam int W  = 8 * NBYTES;
   localparam int N  = 2 * NBYTES;
   localparam int KW = $clog2(N);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [W-1:0]      a_reg;
   logic [W-1:0]      b_reg;
   logic [N-1:0][3:0] sum_reg;
   logic              carry;
   logic              cout_reg;
   logic [KW-1:0]     k;
   logic [W-1:0]      a_shift;
   logic [W-1:0]      b_shift;
   logic [4:0]        t;
   logic              last_step;
   logic              accept;

   // Step k works on byte k>>1; shifting that byte down to bit 0 avoids a
   // variable part-select that would be awkward when NBYTES is 1.
   assign a_shift   = a_reg >> {k >> 1, 3'b000};
   assign b_shift   = b_reg >> {k >> 1, 3'b000};
   assign t         = na_q + {4'b0000, carry};
   assign last_step = (k == KW'(N - 1));
   assign accept    = in_valid && in_ready;

   assign out_sum   = sum_reg;
   assign out_cout  = cout_reg;
   assign busy      = (state != IDLE);

   // State register.
   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples the values from before the edge, independent of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode plus handshake and adder drive outputs.
   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      na_a      = 8'h00;
      na_b      = 8'h00;
      na_ctrl   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !rst;
            if (in_valid && !rst) begin
               state_nxt = ADD;
            end
         end
         ADD: begin
            na_a    = a_shift[7:0];
            na_b    = b_shift[7:0];
            na_ctrl = k[0];
            if (last_step) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, carry ripple and sum assembly.
   // NOTE: the datapath registers are reset as well, because the sum and
   // carry-out ports must read zero after reset, not leftover results.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg    <= '0;
         b_reg    <= '0;
         sum_reg  <= '0;
         carry    <= 1'b0;
         cout_reg <= 1'b0;
         k        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_reg    <= in_a;
                  b_reg    <= in_b;
                  sum_reg  <= '0;
                  carry    <= in_cin;
                  cout_reg <= 1'b0;
                  k        <= '0;
               end
            end
            ADD: begin
               sum_reg[k] <= t[3:0];
               carry      <= t[4];
               k          <= k + KW'(1);
               if (last_step) begin
                  cout_reg <= t[4];
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibbleadd_seq.sv
// Self-checking bench for nibbleadd_seq. A behavioural model (plain addition
// plus a cycle count since acceptance) predicts the handshake, the adder drive
// and the result on every cycle; directed scenarios pin the model to literal
// expectations, and a randomized phase exercises handshakes and resets.
module tb_nibbleadd_seq;

   localparam int NB = 2;
   localparam int W  = 8 * NB;
   localparam int N  = 2 * NB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;

   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic          in_cin = 1'b0;
   logic [7:0]    na_a;
   logic [7:0]    na_b;
   logic          na_ctrl;
   logic [4:0]    na_q;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_sum;
   logic          out_cout;
   logic          busy;

   logic          in_valid1 = 1'b0;
   logic          in_ready1;
   logic [7:0]    in_a1 = '0;
   logic [7:0]    in_b1 = '0;
   logic          in_cin1 = 1'b0;
   logic [7:0]    na_a1;
   logic [7:0]    na_b1;
   logic          na_ctrl1;
   logic [4:0]    na_q1;
   logic          out_valid1;
   logic          out_ready1 = 1'b1;
   logic [7:0]    out_sum1;
   logic          out_cout1;
   logic          busy1;

   int            n_pass = 0;
   int            n_total = 0;
   bit            cmp_on = 1'b0;

   // Model state: pending operation, edges since acceptance, captured operands.
   bit            m_pending = 1'b0;
   int            m_cnt = 0;
   logic [W-1:0]  m_a = '0;
   logic [W-1:0]  m_b = '0;
   logic [W:0]    m_res = '0;

   always #5 clk = ~clk;

   // Behaviour of the external nibble adder.
   function automatic logic [4:0] nib_add(input logic [7:0] a, input logic [7:0] b,
                                          input logic ctrl);
      if (ctrl) return {1'b0, a[7:4]} + {1'b0, b[7:4]};
      return {1'b0, a[3:0]} + {1'b0, b[3:0]};
   endfunction

   assign na_q  = nib_add(na_a, na_b, na_ctrl);
   assign na_q1 = nib_add(na_a1, na_b1, na_ctrl1);

   nibbleadd_seq #(.NBYTES(NB)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
      .na_a(na_a), .na_b(na_b), .na_ctrl(na_ctrl), .na_q(na_q),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
   );

   nibbleadd_seq #(.NBYTES(1)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
      .na_a(na_a1), .na_b(na_b1), .na_ctrl(na_ctrl1), .na_q(na_q1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .out_sum(out_sum1), .out_cout(out_cout1), .busy(busy1)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Model update from pre-edge values: reset, output handshake, acceptance,
   // or one more step of the running operation.
   always @(posedge clk) begin
      if (rst) begin
         m_pending = 1'b0;
         m_cnt     = 0;
      end else if (m_pending && m_cnt == N && out_ready) begin
         m_pending = 1'b0;
      end else if (!m_pending && in_valid) begin
         m_pending = 1'b1;
         m_cnt     = 0;
         m_a       = in_a;
         m_b       = in_b;
         m_res     = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin};
      end else if (m_pending && m_cnt < N) begin
         m_cnt++;
      end
   end

   // Compare every DUT output against the model, mid-cycle.
   logic [W-1:0] sh_a, sh_b;
   logic [7:0]   e_na_a, e_na_b;
   logic         e_na_ctrl;
   always @(negedge clk) begin
      if (cmp_on) begin
         check("in_ready", 64'(in_ready), 64'(!m_pending && !rst));
         check("out_valid", 64'(out_valid), 64'(m_pending && m_cnt == N));
         check("busy", 64'(busy), 64'(m_pending));
         if (m_pending && m_cnt < N) begin
            sh_a      = m_a >> (8 * (m_cnt / 2));
            sh_b      = m_b >> (8 * (m_cnt / 2));
            e_na_a    = sh_a[7:0];
            e_na_b    = sh_b[7:0];
            e_na_ctrl = m_cnt[0];
         end else begin
            e_na_a    = 8'h00;
            e_na_b    = 8'h00;
            e_na_ctrl = 1'b0;
         end
         check("na_a", 64'(na_a), 64'(e_na_a));
         check("na_b", 64'(na_b), 64'(e_na_b));
         check("na_ctrl", 64'(na_ctrl), 64'(e_na_ctrl));
         if (m_pending && m_cnt == N) begin
            check("out_sum", 64'(out_sum), 64'(m_res[W-1:0]));
            check("out_cout", 64'(out_cout), 64'(m_res[W]));
         end
      end
   end

   // One full operation with out_ready held high; checks latency and result.
   task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] es, input logic ec,
                        input bit chk_ctrl);
      logic [W:0] mres;
      logic [3:0] seq;
      bit         seen;
      int         lat;
      mres = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      check({name, "_model"}, 64'(mres), 64'({ec, es}));
      @(posedge clk); #1;
      in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin seen = 1'b1; break; end
      end
      check({name, "_accept"}, 64'(seen), 64'(1));
      if (!seen) return;
      @(posedge clk); #1;
      in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
      seq = '0; seen = 1'b0; lat = 0;
      for (lat = 0; lat < 40; lat++) begin
         @(negedge clk);
         if (out_valid) begin seen = 1'b1; break; end
         if (lat < 4) seq[lat] = na_ctrl;
         @(posedge clk);
      end
      check({name, "_valid_seen"}, 64'(seen), 64'(1));
      check({name, "_latency"}, 64'(lat), 64'(N));
      if (chk_ctrl) check({name, "_ctrl_seq"}, 64'(seq), 64'(4'b1010));
      check({name, "_sum"}, 64'(out_sum), 64'(es));
      check({name, "_cout"}, 64'(out_cout), 64'(ec));
      @(posedge clk); #1;
   endtask

   initial begin
      bit seen;
      int spurious;
      int lat;

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_out_sum", 64'(out_sum), 64'(0));
      check("rst_out_cout", 64'(out_cout), 64'(0));
      check("rst_na", 64'({na_a, na_b, na_ctrl}), 64'(0));
      cmp_on = 1'b1;
      @(posedge clk); #1 rst = 1'b0;

      do_op("basic", 16'h0024, 16'h0081, 1'b0, 16'h00A5, 1'b0, 1'b1);
      do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
      do_op("cin", 16'h76ED, 16'h3D8C, 1'b1, 16'hB47A, 1'b0, 1'b1);
      do_op("overflow", 16'hF9C5, 16'hC6AA, 1'b0, 16'hC06F, 1'b1, 1'b1);

      // Backpressure: result held while the next operand waits.
      @(posedge clk); #1;
      in_a = 16'h0024; in_b = 16'h0081; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid) begin seen = 1'b1; break; end
      end
      check("bp_valid_seen", 64'(seen), 64'(1));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_valid", 64'(out_valid), 64'(1));
         check("bp_hold_sum", 64'(out_sum), 64'(16'h00A5));
         check("bp_hold_cout", 64'(out_cout), 64'(0));
         check("bp_hold_in_ready", 64'(in_ready), 64'(0));
         @(posedge clk); #1;
         if (i == 0) begin in_a = 16'h1111; in_b = 16'h2222; end
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_last_valid", 64'(out_valid), 64'(1));
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_after_valid", 64'(out_valid), 64'(0));
      check("bp_after_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      check("bp_next_busy", 64'(busy), 64'(1));
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid) begin seen = 1'b1; break; end
      end
      check("bp_next_seen", 64'(seen), 64'(1));
      check("bp_next_sum", 64'(out_sum), 64'(16'h3333));
      check("bp_next_cout", 64'(out_cout), 64'(0));
      @(posedge clk); #1;

      // Reset during ADD step 2.
      in_a = 16'h5678; in_b = 16'h9ABC; in_cin = 1'b1; in_valid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin seen = 1'b1; break; end
      end
      check("mid_accept", 64'(seen), 64'(1));
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("mid_step2_ctrl", 64'(na_ctrl), 64'(0));
      check("mid_step2_na_a", 64'(na_a), 64'(8'h56));
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("mid_busy", 64'(busy), 64'(0));
      check("mid_out_valid", 64'(out_valid), 64'(0));
      check("mid_na", 64'({na_a, na_b, na_ctrl}), 64'(0));
      check("mid_out_sum", 64'(out_sum), 64'(0));
      check("mid_in_ready", 64'(in_ready), 64'(1));
      spurious = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) spurious++;
      end
      check("mid_no_result", 64'(spurious), 64'(0));
      do_op("after_rst", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         in_valid  = 1'($urandom);
         in_a      = W'($urandom);
         in_b      = W'($urandom);
         in_cin    = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 199) == 0);
      end
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;

      // Single-byte instance.
      in_a1 = 8'h24; in_b1 = 8'h81; in_cin1 = 1'b0; in_valid1 = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready1) begin seen = 1'b1; break; end
      end
      check("nb1_accept", 64'(seen), 64'(1));
      @(posedge clk); #1 in_valid1 = 1'b0; in_a1 = 8'hFF;
      seen = 1'b0;
      for (lat = 0; lat < 40; lat++) begin
         @(negedge clk);
         if (out_valid1) begin seen = 1'b1; break; end
         @(posedge clk);
      end
      check("nb1_valid_seen", 64'(seen), 64'(1));
      check("nb1_latency", 64'(lat), 64'(2));
      check("nb1_sum", 64'(out_sum1), 64'(8'hA5));
      check("nb1_cout", 64'(out_cout1), 64'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check("nb1_idle", 64'({out_valid1, busy1}), 64'(0));

      cmp_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
